// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory port controller: FSM states,
// access size codes, I/O region select and the size-to-byte-count helper.
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        IF_RD,
        D_RD,
        D_WR,
        IO_WAIT
    } state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam logic [1:0] IO_SEL = 2'b11;

    // Size code 3 is treated as a word access.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            SZ_W:    return 3'd4;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Memory-bus controller: serialises icache fetches and dcache loads/stores onto
// the single byte-wide RAM/IO port, with data-side priority and UART back-pressure.
module mem_ctrl #(
    parameter logic [1:0]  IO_SEL = mem_ctrl_pkg::IO_SEL,
    parameter int unsigned XLEN   = 32
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,
    input  logic            clear,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_done,
    output logic [XLEN-1:0] if_data,
    input  logic            d_req,
    input  logic            d_wr,
    input  logic [1:0]      d_size,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    output logic            d_done,
    output logic [XLEN-1:0] d_rdata,
    input  logic [7:0]      mem_din,
    output logic [7:0]      mem_dout,
    output logic [XLEN-1:0] mem_a,
    output logic            mem_wr,
    input  logic            io_buffer_full
);
    import mem_ctrl_pkg::*;

    state_t          state_q;
    logic [2:0]      cnt_q;     // next byte to issue
    logic [2:0]      rcv_q;     // next byte to capture
    logic [2:0]      nbytes_q;
    logic [XLEN-1:0] base_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] rbuf_q;
    logic            pend_q;    // a read byte was issued last cycle
    logic            stall_q;   // an in-flight read byte was lost to rdy_in low
    logic            wr_q;

    logic [2:0]      cnt_inc;
    logic [XLEN-1:0] addr_inc;
    logic [XLEN-1:0] addr_rew;
    logic [XLEN-1:0] word_next;
    logic [7:0]      byte_inc;
    logic            io_inc;
    logic            io_acc;
    logic            last_rd;
    logic            last_wr;

    always_comb begin
        cnt_inc   = cnt_q + 3'd1;
        addr_inc  = base_q + XLEN'(cnt_inc);
        addr_rew  = base_q + XLEN'(rcv_q);
        byte_inc  = wdata_q[{cnt_inc[1:0], 3'b000} +: 8];
        io_inc    = (addr_inc[17:16] == IO_SEL);
        io_acc    = (d_addr[17:16] == IO_SEL);
        word_next = rbuf_q;
        word_next[{rcv_q[1:0], 3'b000} +: 8] = mem_din;
        last_rd   = pend_q && (rcv_q == nbytes_q - 3'd1);
        last_wr   = (cnt_q == nbytes_q - 3'd1);
    end

    // Write strobe drops combinationally with rdy_in so a frozen cycle never writes.
    assign mem_wr = wr_q & rdy_in;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rcv_q    <= '0;
            nbytes_q <= '0;
            base_q   <= '0;
            wdata_q  <= '0;
            rbuf_q   <= '0;
            pend_q   <= 1'b0;
            stall_q  <= 1'b0;
            wr_q     <= 1'b0;
            if_done  <= 1'b0;
            d_done   <= 1'b0;
            if_data  <= '0;
            d_rdata  <= '0;
            mem_a    <= '0;
            mem_dout <= '0;
        end else if (!rdy_in) begin
            if ((state_q == IF_RD || state_q == D_RD) && pend_q) begin
                stall_q <= 1'b1;
            end
        end else begin
            if_done <= 1'b0;
            d_done  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!if_done && !d_done) begin
                        if (d_req) begin
                            base_q   <= d_addr;
                            wdata_q  <= d_wdata;
                            nbytes_q <= size_bytes(d_size);
                            cnt_q    <= '0;
                            rcv_q    <= '0;
                            pend_q   <= 1'b0;
                            stall_q  <= 1'b0;
                            rbuf_q   <= '0;
                            mem_a    <= d_addr;
                            mem_dout <= d_wdata[7:0];
                            if (!d_wr) begin
                                state_q <= D_RD;
                            end else if (io_acc && io_buffer_full) begin
                                state_q <= IO_WAIT;
                            end else begin
                                state_q <= D_WR;
                                wr_q    <= 1'b1;
                            end
                        end else if (if_req && !clear) begin
                            base_q   <= if_addr;
                            nbytes_q <= size_bytes(SZ_W);
                            cnt_q    <= '0;
                            rcv_q    <= '0;
                            pend_q   <= 1'b0;
                            stall_q  <= 1'b0;
                            rbuf_q   <= '0;
                            mem_a    <= if_addr;
                            state_q  <= IF_RD;
                        end
                    end
                end
                IF_RD, D_RD: begin
                    if (clear) begin
                        state_q <= IDLE;
                        mem_a   <= '0;
                        pend_q  <= 1'b0;
                        stall_q <= 1'b0;
                    end else if (stall_q) begin
                        // Re-issue from the first uncaptured byte.
                        cnt_q   <= rcv_q;
                        mem_a   <= addr_rew;
                        pend_q  <= 1'b0;
                        stall_q <= 1'b0;
                    end else if (last_rd) begin
                        state_q <= IDLE;
                        mem_a   <= '0;
                        pend_q  <= 1'b0;
                        if (state_q == IF_RD) begin
                            if_done <= 1'b1;
                            if_data <= word_next;
                        end else begin
                            d_done  <= 1'b1;
                            d_rdata <= word_next;
                        end
                    end else begin
                        if (pend_q) begin
                            rbuf_q <= word_next;
                            rcv_q  <= rcv_q + 3'd1;
                        end
                        if (cnt_q < nbytes_q) begin
                            pend_q <= 1'b1;
                            cnt_q  <= cnt_inc;
                            if (cnt_inc < nbytes_q) begin
                                mem_a <= addr_inc;
                            end
                        end else begin
                            pend_q <= 1'b0;
                        end
                    end
                end
                D_WR: begin
                    if (last_wr) begin
                        state_q <= IDLE;
                        wr_q    <= 1'b0;
                        mem_a   <= '0;
                        d_done  <= 1'b1;
                    end else begin
                        cnt_q    <= cnt_inc;
                        mem_a    <= addr_inc;
                        mem_dout <= byte_inc;
                        if (io_inc && io_buffer_full) begin
                            state_q <= IO_WAIT;
                            wr_q    <= 1'b0;
                        end else begin
                            wr_q <= 1'b1;
                        end
                    end
                end
                IO_WAIT: begin
                    if (!io_buffer_full) begin
                        state_q <= D_WR;
                        wr_q    <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: expected dones and writes are queued with their
// due cycle when a request is driven and retired as the DUT produces them.
module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clear;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        d_req;
    logic        d_wr;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_done;
    logic [31:0] d_rdata;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        int          c;    // due cycle, -1 = any
        bit          chk;  // compare data
    } exp_t;

    exp_t exp_if[$];
    exp_t exp_d[$];
    exp_t exp_w[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    mem_ctrl dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .clear         (clear),
        .if_req        (if_req),
        .if_addr       (if_addr),
        .if_done       (if_done),
        .if_data       (if_data),
        .d_req         (d_req),
        .d_wr          (d_wr),
        .d_size        (d_size),
        .d_addr        (d_addr),
        .d_wdata       (d_wdata),
        .d_done        (d_done),
        .d_rdata       (d_rdata),
        .mem_din       (mem_din),
        .mem_dout      (mem_dout),
        .mem_a         (mem_a),
        .mem_wr        (mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [7:0] ram_byte(input logic [31:0] a);
        case (a)
            32'h100:  return 8'h13;
            32'h101:  return 8'h05;
            32'h102:  return 8'h00;
            32'h103:  return 8'h00;
            32'h2000: return 8'hEF;
            32'h2001: return 8'hBE;
            32'h2002: return 8'hAD;
            32'h2003: return 8'hDE;
            32'h20:   return 8'hAA;
            32'h21:   return 8'hBB;
            default:  return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    always @(posedge clk_in) mem_din <= ram_byte(mem_a);

    // Advance to the next sampling point and retire any DUT events.
    task automatic step();
        exp_t e;
        @(negedge clk_in);
        cyc++;
        if (if_done) begin
            checks++;
            if (exp_if.size() == 0) begin
                errors++;
                $display("FAIL if_done: unexpected pulse at cycle %0d data %h", cyc, if_data);
            end else begin
                e = exp_if.pop_front();
                if (if_data !== e.d || (e.c >= 0 && cyc != e.c)) begin
                    errors++;
                    $display("FAIL if_done: got %h at cycle %0d, want %h at cycle %0d",
                             if_data, cyc, e.d, e.c);
                end
            end
            if_req = 1'b0;
        end
        if (d_done) begin
            checks++;
            if (exp_d.size() == 0) begin
                errors++;
                $display("FAIL d_done: unexpected pulse at cycle %0d", cyc);
            end else begin
                e = exp_d.pop_front();
                if ((e.chk && d_rdata !== e.d) || (e.c >= 0 && cyc != e.c)) begin
                    errors++;
                    $display("FAIL d_done: got %h at cycle %0d, want %h at cycle %0d",
                             d_rdata, cyc, e.d, e.c);
                end
            end
            d_req = 1'b0;
        end
        if (mem_wr) begin
            checks++;
            if (exp_w.size() == 0) begin
                errors++;
                $display("FAIL write: unexpected write %h to %h at cycle %0d", mem_dout, mem_a, cyc);
            end else begin
                e = exp_w.pop_front();
                if (mem_a !== e.a || mem_dout !== e.d[7:0] || cyc != e.c) begin
                    errors++;
                    $display("FAIL write: got %h@%h cycle %0d, want %h@%h cycle %0d",
                             mem_dout, mem_a, cyc, e.d[7:0], e.a, e.c);
                end
            end
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_if.size() + exp_d.size() + exp_w.size()) != 0 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if ((exp_if.size() + exp_d.size() + exp_w.size()) != 0) begin
            errors++;
            $display("FAIL %s: %0d expected events never seen, want 0", name,
                     exp_if.size() + exp_d.size() + exp_w.size());
            exp_if.delete();
            exp_d.delete();
            exp_w.delete();
        end
        step();
        step();
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        #12;
        checks += 4;
        if ({if_done, d_done, mem_wr} !== 3'b000) begin
            errors++;
            $display("FAIL reset_strobes: got %b, want 000", {if_done, d_done, mem_wr});
        end
        if (if_data !== 32'h0 || d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got %h/%h, want 0/0", if_data, d_rdata);
        end
        if (mem_a !== 32'h0) begin
            errors++;
            $display("FAIL reset_mem_a: got %h, want 0", mem_a);
        end
        if (mem_dout !== 8'h0) begin
            errors++;
            $display("FAIL reset_mem_dout: got %h, want 0", mem_dout);
        end
        @(negedge clk_in);
        rst_in = 1'b1;
        step();
        step();
    endtask

    task automatic test_fetch(input string name);
        int t;
        t = cyc;
        if_addr = 32'h100;
        if_req  = 1'b1;
        exp_if.push_back('{32'h100, 32'h0000_0513, t + 6, 1'b1});
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++;
            if (mem_a !== 32'h100 + 32'(k - 1) || mem_wr !== 1'b0) begin
                errors++;
                $display("FAIL %s_issue%0d: got a=%h wr=%b, want a=%h wr=0", name, k, mem_a,
                         mem_wr, 32'h100 + 32'(k - 1));
            end
        end
        drain(name);
    endtask

    task automatic test_contention();
        int t;
        t = cyc;
        if_addr = 32'h100;
        if_req  = 1'b1;
        d_addr  = 32'h2000;
        d_size  = 2'd2;
        d_wr    = 1'b0;
        d_req   = 1'b1;
        exp_d.push_back('{32'h2000, 32'hDEAD_BEEF, t + 6, 1'b1});
        exp_if.push_back('{32'h100, 32'h0000_0513, t + 13, 1'b1});
        for (int k = 1; k <= 13; k++) begin
            step();
            if (k == 1 || k == 7 || k == 8) begin
                checks++;
                if (mem_a !== (k == 1 ? 32'h2000 : (k == 7 ? 32'h0 : 32'h100))) begin
                    errors++;
                    $display("FAIL contention_a%0d: got %h", k, mem_a);
                end
            end
        end
        drain("contention");
    endtask

    task automatic test_io_store();
        int t;
        t = cyc;
        io_buffer_full = 1'b1;
        d_addr  = 32'h30000;
        d_wdata = 32'h1234_5641;
        d_size  = 2'd0;
        d_wr    = 1'b1;
        d_req   = 1'b1;
        exp_w.push_back('{32'h30000, 32'h41, t + 4, 1'b1});
        exp_d.push_back('{32'h0, 32'h0, t + 5, 1'b0});
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++;
            if (mem_wr !== 1'b0 || mem_a !== 32'h30000) begin
                errors++;
                $display("FAIL io_wait%0d: got wr=%b a=%h, want wr=0 a=00030000", k, mem_wr, mem_a);
            end
        end
        io_buffer_full = 1'b0;
        drain("io_store");
    endtask

    task automatic test_flush();
        int t;
        t = cyc;
        if_addr = 32'h100;
        if_req  = 1'b1;
        for (int k = 1; k <= 3; k++) step();
        checks++;
        if (mem_a !== 32'h102) begin
            errors++;
            $display("FAIL flush_pre: got %h, want 00000102", mem_a);
        end
        clear  = 1'b1;
        if_req = 1'b0;
        step();
        clear = 1'b0;
        for (int k = 4; k <= 6; k++) begin
            checks++;
            if (mem_a !== 32'h0) begin
                errors++;
                $display("FAIL flush_idle%0d: got %h, want 0", k, mem_a);
            end
            step();
        end
        t = cyc;
        d_addr  = 32'h10;
        d_wdata = 32'hFFFF_B2B1;
        d_size  = 2'd1;
        d_wr    = 1'b1;
        d_req   = 1'b1;
        exp_w.push_back('{32'h10, 32'hB1, t + 1, 1'b1});
        exp_w.push_back('{32'h11, 32'hB2, t + 2, 1'b1});
        exp_d.push_back('{32'h0, 32'h0, t + 3, 1'b0});
        step();
        clear = 1'b1;
        step();
        step();
        clear = 1'b0;
        drain("flush_store");
    endtask

    task automatic test_stall();
        d_addr = 32'h20;
        d_size = 2'd1;
        d_wr   = 1'b0;
        d_req  = 1'b1;
        exp_d.push_back('{32'h20, 32'h0000_BBAA, -1, 1'b1});
        step();
        checks++;
        if (mem_a !== 32'h20) begin
            errors++;
            $display("FAIL stall_issue0: got %h, want 00000020", mem_a);
        end
        step();
        rdy_in = 1'b0;
        step();
        checks++;
        if (mem_a !== 32'h21 || d_done !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold: got a=%h done=%b, want a=00000021 done=0", mem_a, d_done);
        end
        step();
        rdy_in = 1'b1;
        drain("stall");
    endtask

    task automatic test_reset_mid();
        int t;
        t = cyc;
        d_addr  = 32'h40;
        d_wdata = 32'h4433_2211;
        d_size  = 2'd2;
        d_wr    = 1'b1;
        d_req   = 1'b1;
        exp_w.push_back('{32'h40, 32'h11, t + 1, 1'b1});
        exp_w.push_back('{32'h41, 32'h22, t + 2, 1'b1});
        step();
        step();
        rst_in = 1'b0;
        #1;
        checks++;
        if (mem_wr !== 1'b0 || mem_a !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: got wr=%b a=%h, want wr=0 a=0", mem_wr, mem_a);
        end
        d_req = 1'b0;
        step();
        rst_in = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (mem_a !== 32'h0 || d_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_after%0d: got a=%h done=%b, want a=0 done=0", k, mem_a, d_done);
            end
        end
        drain("reset_mid");
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rdy_in         = 1'b1;
        clear          = 1'b0;
        if_req         = 1'b0;
        if_addr        = '0;
        d_req          = 1'b0;
        d_wr           = 1'b0;
        d_size         = '0;
        d_addr         = '0;
        d_wdata        = '0;
        io_buffer_full = 1'b0;
        test_reset();
        test_fetch("fetch");
        test_contention();
        test_io_store();
        test_flush();
        test_stall();
        test_reset_mid();
        test_fetch("back_to_back");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
